// File: rtl/dpd_adapt_ctrl_pkg.sv
// Shared DPD package: adaptation FSM state encoding and common unsigned
// word types used by the DPD control blocks.
package dpd_adapt_ctrl_pkg;

  localparam int unsigned ADAPT_STATE_W = 2;

  typedef logic [19:0] u20;
  typedef logic [31:0] u32;

  typedef enum logic [ADAPT_STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ADAPT  = 2'd2,
    ST_EVAL   = 2'd3
  } adapt_state_t;

endpackage

// File: rtl/dpd_adapt_ctrl.sv
// dpd_adapt_ctrl: sequences DPD adaptation runs as repeated
// SETTLE -> ADAPT -> EVAL iterations.
// Optional feature macro: DPD_ADAPT_CTRL_ERR_STOP_EN (early stop when the
// fit error drops to or below the snapshot threshold).
// Ports:
//   clk, reset_b      clock, async active-low reset
//   start, abort      run request (IDLE only) / immediate termination
//   settle_len        SETTLE cycles per iteration (0 treated as 1)
//   adapt_len         ADAPT cycles per iteration (0 treated as 1)
//   n_iter            iterations per run, 0 = run until abort
//   err_thr           convergence threshold (used only with the macro)
//   err_fit_mag       fit error from the DPD core, sampled in EVAL
//   dpd_adapt, busy   adaptation enable / run in progress
//   done, converged   completion pulse / sticky threshold-stop flag
//   iter_cnt, err_last completed iterations / last sampled error
module dpd_adapt_ctrl
  import dpd_adapt_ctrl_pkg::*;
#(
  parameter int unsigned CW = $bits(u32),
  parameter int unsigned IW = 8,
  parameter int unsigned EW = $bits(u20)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] settle_len,
  input  logic [CW-1:0] adapt_len,
  input  logic [IW-1:0] n_iter,
  input  logic [EW-1:0] err_thr,
  input  logic [EW-1:0] err_fit_mag,
  output logic          dpd_adapt,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [IW-1:0] iter_cnt,
  output logic [EW-1:0] err_last
);

  localparam int unsigned SW = ADAPT_STATE_W;
  localparam logic [SW-1:0] IDLE   = SW'(ST_IDLE);
  localparam logic [SW-1:0] SETTLE = SW'(ST_SETTLE);
  localparam logic [SW-1:0] ADAPT  = SW'(ST_ADAPT);
  localparam logic [SW-1:0] EVAL   = SW'(ST_EVAL);

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] adapt_q, adapt_d;
  logic [IW-1:0] niter_q, niter_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [IW-1:0] iter_inc;
  logic [EW-1:0] err_q, err_d;
  logic          dpd_q, dpd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hit_c;

`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
  logic [EW-1:0] thr_q, thr_d;
  logic          conv_q, conv_d;
  assign hit_c     = (err_fit_mag <= thr_q);
  assign converged = conv_q;
`else
  logic unused_err_thr;
  assign unused_err_thr = ^err_thr;
  assign hit_c          = 1'b0;
  assign converged      = 1'b0;
`endif

  // Down-counter reload value: a phase lasts max(len,1) cycles.
  function automatic logic [CW-1:0] load_val(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - CW'(1);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    adapt_d  = adapt_q;
    niter_d  = niter_q;
    iter_d   = iter_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
    thr_d    = thr_q;
    conv_d   = conv_q;
`endif
    iter_inc = (iter_q == {IW{1'b1}}) ? iter_q : iter_q + IW'(1);

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            settle_d = settle_len;
            adapt_d  = adapt_len;
            niter_d  = n_iter;
            iter_d   = '0;
            cnt_d    = load_val(settle_len);
            state_d  = SETTLE;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
            thr_d    = err_thr;
            conv_d   = 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            cnt_d   = load_val(adapt_q);
            state_d = ADAPT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ADAPT: begin
          if (cnt_q == '0) begin
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        EVAL: begin
          err_d  = err_fit_mag;
          iter_d = iter_inc;
          if (hit_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
            conv_d  = 1'b1;
`endif
          end else if ((niter_q != '0) && (iter_inc == niter_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = load_val(settle_q);
            state_d = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    dpd_d  = (state_d == ADAPT);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      adapt_q  <= '0;
      niter_q  <= '0;
      iter_q   <= '0;
      err_q    <= '0;
      dpd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
      thr_q    <= '0;
      conv_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      adapt_q  <= adapt_d;
      niter_q  <= niter_d;
      iter_q   <= iter_d;
      err_q    <= err_d;
      dpd_q    <= dpd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
      thr_q    <= thr_d;
      conv_q   <= conv_d;
`endif
    end
  end

  assign dpd_adapt = dpd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign iter_cnt  = iter_q;
  assign err_last  = err_q;

endmodule

// File: tb/tb_dpd_adapt_ctrl.sv
// Directed self-checking bench for dpd_adapt_ctrl. Cycle 0 is the cycle in
// which start is high; outputs for cycle c are sampled on the falling edge
// inside cycle c.
module tb_dpd_adapt_ctrl;

  localparam int unsigned CW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned EW = 20;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          start, abort;
  logic [CW-1:0] settle_len, adapt_len;
  logic [IW-1:0] n_iter;
  logic [EW-1:0] err_thr, err_fit_mag;
  logic          dpd_adapt, busy, done, converged;
  logic [IW-1:0] iter_cnt;
  logic [EW-1:0] err_last;

  logic          start2, abort2;
  logic [1:0]    n_iter2;
  logic          dpd_adapt2, busy2, done2, converged2;
  logic [1:0]    iter_cnt2;
  logic [EW-1:0] err_last2;

  int checks = 0;
  int passed = 0;

  logic [63:0] dpd_m, busy_m, done_m, exp_m;

  always #5 clk = ~clk;

  dpd_adapt_ctrl #(.CW(CW), .IW(IW), .EW(EW)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
    .settle_len(settle_len), .adapt_len(adapt_len), .n_iter(n_iter),
    .err_thr(err_thr), .err_fit_mag(err_fit_mag),
    .dpd_adapt(dpd_adapt), .busy(busy), .done(done), .converged(converged),
    .iter_cnt(iter_cnt), .err_last(err_last)
  );

  dpd_adapt_ctrl #(.CW(CW), .IW(2), .EW(EW)) dut_sat (
    .clk(clk), .reset_b(reset_b), .start(start2), .abort(abort2),
    .settle_len(settle_len), .adapt_len(adapt_len), .n_iter(n_iter2),
    .err_thr(err_thr), .err_fit_mag(err_fit_mag),
    .dpd_adapt(dpd_adapt2), .busy(busy2), .done(done2), .converged(converged2),
    .iter_cnt(iter_cnt2), .err_last(err_last2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  // Capture per-cycle dpd/busy/done for cycles 1..n after a start at cycle 0.
  task automatic run_capture(input int n);
    dpd_m = '0; busy_m = '0; done_m = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      dpd_m[c] = dpd_adapt; busy_m[c] = busy; done_m[c] = done;
      if (c == 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dpd_adapt !== 1'b0) $display("FAIL rst_dpd: got %b expected 0", dpd_adapt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
    checks++; if (converged !== 1'b0) $display("FAIL rst_conv: got %b expected 0", converged); else passed++;
    checks++; if (iter_cnt !== 8'd0) $display("FAIL rst_iter: got %0d expected 0", iter_cnt); else passed++;
    checks++; if (err_last !== 20'd0) $display("FAIL rst_err: got %0d expected 0", err_last); else passed++;
    @(negedge clk); reset_b = 1'b1;
    busy_m = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); busy_m[c] = busy | dpd_adapt | done;
    end
    checks++; if (busy_m !== 64'd0) $display("FAIL idle_after_rst: got %h expected 0", busy_m); else passed++;
  endtask

  task automatic test_basic_run();
    @(negedge clk);
    settle_len = 3; adapt_len = 5; n_iter = 2; err_thr = 0; err_fit_mag = 20'd123;
    start = 1'b1;
    @(posedge clk); #1;
    settle_len = 50; adapt_len = 50; n_iter = 7;
    @(negedge clk);
    dpd_m = '0; busy_m = '0; done_m = '0;
    dpd_m[1] = dpd_adapt; busy_m[1] = busy; done_m[1] = done;
    start = 1'b0;
    for (int c = 2; c <= 24; c++) begin
      @(negedge clk);
      dpd_m[c] = dpd_adapt; busy_m[c] = busy; done_m[c] = done;
      if (c == 19) begin
        checks++; if (iter_cnt !== 8'd2) $display("FAIL basic_iter: got %0d expected 2", iter_cnt); else passed++;
        checks++; if (err_last !== 20'd123) $display("FAIL basic_err: got %0d expected 123", err_last); else passed++;
      end
    end
    exp_m = '0; for (int c = 4; c <= 8; c++) exp_m[c] = 1'b1; for (int c = 13; c <= 17; c++) exp_m[c] = 1'b1;
    chk("basic_dpd", dpd_m, exp_m);
    exp_m = '0; for (int c = 1; c <= 18; c++) exp_m[c] = 1'b1;
    chk("basic_busy", busy_m, exp_m);
    exp_m = '0; exp_m[19] = 1'b1;
    chk("basic_done", done_m, exp_m);
    checks++; if (converged !== 1'b0) $display("FAIL basic_conv: got %b expected 0", converged); else passed++;
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    settle_len = 0; adapt_len = 0; n_iter = 1; err_fit_mag = 20'd7;
    start = 1'b1;
    run_capture(8);
    exp_m = '0; exp_m[2] = 1'b1;
    chk("zero_dpd", dpd_m, exp_m);
    exp_m = '0; exp_m[1] = 1'b1; exp_m[2] = 1'b1; exp_m[3] = 1'b1;
    chk("zero_busy", busy_m, exp_m);
    exp_m = '0; exp_m[4] = 1'b1;
    chk("zero_done", done_m, exp_m);
    checks++; if (iter_cnt !== 8'd1) $display("FAIL zero_iter: got %0d expected 1", iter_cnt); else passed++;
  endtask

  task automatic test_err_stop();
    int done_at;
    int exp_at, exp_iter;
    logic exp_conv;
`ifdef DPD_ADAPT_CTRL_ERR_STOP_EN
    exp_at = 4; exp_iter = 1; exp_conv = 1'b1;
`else
    exp_at = 31; exp_iter = 10; exp_conv = 1'b0;
`endif
    @(negedge clk);
    settle_len = 1; adapt_len = 1; n_iter = 10; err_thr = 20'd1000; err_fit_mag = 20'd900;
    start = 1'b1;
    done_at = -1;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) done_at = c;
    end
    checks++; if (done_at != exp_at) $display("FAIL errstop_done_cycle: got %0d expected %0d", done_at, exp_at); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (converged !== exp_conv) $display("FAIL errstop_conv: got %b expected %b", converged, exp_conv); else passed++;
    checks++; if (iter_cnt !== IW'(exp_iter)) $display("FAIL errstop_iter: got %0d expected %0d", iter_cnt, exp_iter); else passed++;
    err_thr = 0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (converged !== 1'b0) $display("FAIL conv_clear: got %b expected 0", converged); else passed++;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    @(negedge clk);
    settle_len = 1; adapt_len = 4; n_iter = 0; err_thr = 0; err_fit_mag = 20'd555;
    start = 1'b1;
    dpd_m = '0; busy_m = '0; done_m = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 50) begin
        checks++; if (dpd_adapt !== 1'b1) $display("FAIL abort_pre_dpd: got %b expected 1", dpd_adapt); else passed++;
        abort = 1'b1;
      end
      if (c == 51) begin
        abort = 1'b0;
        err_fit_mag = 20'd777;
      end
      if (c >= 51) begin dpd_m[c] = dpd_adapt; busy_m[c] = busy; end
      done_m[c] = done;
    end
    chk("abort_dpd", dpd_m, 64'd0);
    chk("abort_busy", busy_m, 64'd0);
    chk("abort_nodone", done_m, 64'd0);
    checks++; if (iter_cnt !== 8'd8) $display("FAIL abort_iter: got %0d expected 8", iter_cnt); else passed++;
    checks++; if (err_last !== 20'd555) $display("FAIL abort_err: got %0d expected 555", err_last); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    settle_len = 3; adapt_len = 5; n_iter = 2; err_thr = 0; err_fit_mag = 20'd42;
    start = 1'b1;
    dpd_m = '0; done_m = '0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      dpd_m[c] = dpd_adapt; done_m[c] = done;
      if (c == 1) start = 1'b0;
      if (c == 6 || c == 9) begin start = 1'b1; settle_len = 0; adapt_len = 0; n_iter = 1; end
      if (c == 7 || c == 10) start = 1'b0;
    end
    exp_m = '0; for (int c = 4; c <= 8; c++) exp_m[c] = 1'b1; for (int c = 13; c <= 17; c++) exp_m[c] = 1'b1;
    chk("restart_dpd", dpd_m, exp_m);
    exp_m = '0; exp_m[19] = 1'b1;
    chk("restart_done", done_m, exp_m);
    // Reset asserted mid-ADAPT clears everything without a clock edge.
    @(negedge clk);
    settle_len = 3; adapt_len = 5; n_iter = 2;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++; if (dpd_adapt !== 1'b1) $display("FAIL pre_rst_dpd: got %b expected 1", dpd_adapt); else passed++;
    #2 reset_b = 1'b0;
    #1;
    checks++; if ({dpd_adapt, busy, done, converged} !== 4'b0) $display("FAIL midrst_flags: got %b expected 0000", {dpd_adapt, busy, done, converged}); else passed++;
    checks++; if (err_last !== 20'd0) $display("FAIL midrst_err: got %0d expected 0", err_last); else passed++;
    @(negedge clk); reset_b = 1'b1;
    busy_m = '0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); busy_m[c] = busy; end
    chk("post_rst_idle", busy_m, 64'd0);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    settle_len = 1; adapt_len = 1; n_iter2 = 2'd0; err_thr = 0; err_fit_mag = 20'd9;
    start2 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (c == 7) begin
        checks++; if (iter_cnt2 !== 2'd2) $display("FAIL sat_iter7: got %0d expected 2", iter_cnt2); else passed++;
      end
      if (c == 10) begin
        checks++; if (iter_cnt2 !== 2'd3) $display("FAIL sat_iter10: got %0d expected 3", iter_cnt2); else passed++;
      end
    end
    checks++; if (iter_cnt2 !== 2'd3) $display("FAIL sat_iter16: got %0d expected 3", iter_cnt2); else passed++;
    checks++; if (busy2 !== 1'b1) $display("FAIL sat_busy: got %b expected 1", busy2); else passed++;
    abort2 = 1'b1;
    @(negedge clk); abort2 = 1'b0;
    checks++; if (busy2 !== 1'b0) $display("FAIL sat_abort: got %b expected 0", busy2); else passed++;
  endtask

  initial begin
    reset_b = 1'b0; start = 1'b0; abort = 1'b0;
    settle_len = '0; adapt_len = '0; n_iter = '0; err_thr = '0; err_fit_mag = '0;
    start2 = 1'b0; abort2 = 1'b0; n_iter2 = '0;
    test_reset();
    test_basic_run();
    test_zero_len();
    test_err_stop();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dpd_adapt_ctrl.md
DPD_ADAPT_CTRL -- requirements
Module: dpd_adapt_ctrl

Interface
REQ-001 Parameter CW, default 32: width of the settle and adapt cycle counters.
REQ-002 Parameter IW, default 8: width of the iteration count.
REQ-003 Parameter EW, default 20: width of the error magnitude and threshold.
REQ-004 clk  in  1  clock.
REQ-005 reset_b  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  1-cycle request to begin an adaptation run.
REQ-007 abort  in  1  terminates the run immediately.
REQ-008 settle_len  in  CW  cycles in SETTLE per iteration (PA loopback flush).
REQ-009 adapt_len  in  CW  cycles dpd_adapt is held high per iteration.
REQ-010 n_iter  in  IW  iterations per run; 0 = free-running until abort.
REQ-011 err_thr  in  EW  unsigned convergence threshold.
REQ-012 err_fit_mag  in  EW  unsigned fit error from the DPD core.
REQ-013 dpd_adapt  out  1  adaptation enable to the DPD core.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 done  out  1  1-cycle pulse on normal run completion.
REQ-016 converged  out  1  sticky flag: the run ended on threshold; cleared by the next accepted start.
REQ-017 iter_cnt  out  IW  completed iterations in the current or last run.
REQ-018 err_last  out  EW  err_fit_mag sampled in the last EVAL.

Function
REQ-019 The FSM SHALL have four states: IDLE, SETTLE, ADAPT and EVAL; every output SHALL be registered.
REQ-020 In IDLE, start SHALL snapshot settle_len, adapt_len, n_iter and err_thr, clear iter_cnt and converged, and enter SETTLE; start outside IDLE SHALL be ignored.
REQ-021 SETTLE SHALL last max(settle_len,1) cycles, then enter ADAPT.
REQ-022 ADAPT SHALL last max(adapt_len,1) cycles, then enter EVAL.
REQ-023 dpd_adapt SHALL be high in exactly the cycles in which the state is ADAPT.
REQ-024 EVAL SHALL last 1 cycle, latch err_last from err_fit_mag, and increment iter_cnt, saturating at 2^IW-1.
REQ-025 EVAL exit, evaluated in order: convergence (per REQ-032) -> IDLE with converged=1 and done; otherwise, if n_iter!=0 and the incremented iter_cnt equals n_iter -> IDLE with done; otherwise -> SETTLE.
REQ-026 done SHALL pulse in the first IDLE cycle after a terminating EVAL.
REQ-027 abort SHALL have priority over start and all transitions: from any state, go to IDLE on the next cycle, with dpd_adapt low, no done pulse, and iter_cnt/err_last held.
REQ-028 Configuration inputs changed mid-run SHALL have no effect until the next start.

Reset
REQ-029 Asserting reset_b low SHALL force state IDLE, dpd_adapt=0, busy=0, done=0, converged=0, iter_cnt=0, err_last=0 and counters=0, asynchronously and at any time, including mid-run.
REQ-030 After reset release, the block SHALL stay in IDLE until a start.

Configuration
REQ-031 Macro DPD_ADAPT_CTRL_ERR_STOP_EN SHALL control early stopping on error.
REQ-032 With DPD_ADAPT_CTRL_ERR_STOP_EN defined, EVAL SHALL treat err_fit_mag <= snapshot err_thr as convergence.
REQ-033 Without DPD_ADAPT_CTRL_ERR_STOP_EN, convergence SHALL never occur, converged SHALL be tied 0, err_thr SHALL be unused, and runs SHALL end only on n_iter or abort.

Structure
REQ-034 The state enum adapt_state_t SHALL be defined in the shared DPD package.
REQ-035 The block SHALL use the package types u20 and u32 where EW=20 and CW=32.
REQ-036 The block SHALL contain no sub-module; a single CW-bit down-counter SHALL be shared by SETTLE and ADAPT.

Verification
REQ-037 settle=3, adapt=5, n_iter=2, start at cycle 0 -> dpd_adapt high in cycles 4-8 and 13-17, done in cycle 19, iter_cnt=2.
REQ-038 settle=0, adapt=0, n_iter=1 -> one SETTLE, one ADAPT and one EVAL cycle, done in cycle 4.
REQ-039 ERR_STOP_EN, err_thr=1000, err_fit_mag=900 from the first EVAL, n_iter=10 -> done after iteration 1, converged=1; without the macro, 10 iterations and converged=0.
REQ-040 n_iter=0 with abort at cycle 50 -> dpd_adapt low from cycle 51, busy low, no done pulse.
REQ-041 start re-pulsed mid-run -> ignored; reset_b low mid-ADAPT -> all outputs 0 immediately.
REQ-042 IW=2, n_iter=0, 5 iterations -> iter_cnt saturates at 3.
